// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared bus widths, arbiter state type and round-robin pick helper
package wb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Scans from last+1 upward, wrapping mod n; the smallest offset with a request wins.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input int n);
    logic [2:0] win;
    logic [2:0] idx;
    win = last;
    for (int k = 8; k >= 1; k--) begin
      if (k <= n) begin
        idx = 3'((int'(last) + k) % n);
        if (req[idx]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// rtl/wb_rr_picker.sv - combinational round-robin priority encoder (req, last -> winner, valid)
module wb_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [IDX_W-1:0]       winner_o,
  output logic                   valid_o
);
  import wb_pkg::*;

  always_comb begin
    winner_o = IDX_W'(rr_pick(8'(req_i), 3'(last_i), NUM_MASTERS));
    valid_o  = |req_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin Wishbone classic arbiter, one slave shared by NUM_MASTERS masters
// Optional watchdog: define WB_ARB_TIMEOUT_EN to enable the TIMEOUT stall counter and m_err_o.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                 m_stb_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]                  m_dat_o,
  output logic [NUM_MASTERS-1:0]                 m_ack_o,
  output logic [NUM_MASTERS-1:0]                 m_err_o,
  output logic                                   s_cyc_o,
  output logic                                   s_stb_o,
  output logic                                   s_we_o,
  output logic [ADDR_WIDTH-1:0]                  s_adr_o,
  output logic [DATA_WIDTH-1:0]                  s_dat_o,
  input  logic [DATA_WIDTH-1:0]                  s_dat_i,
  input  logic                                   s_ack_i,
  output logic [NUM_MASTERS-1:0]                 gnt_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 1) begin : g_param_check
    $error("wb_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT positive");
  end

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       own_q, own_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       pick_win;
  logic                   pick_valid;
  logic                   active;
  logic                   abort;

  wb_rr_picker #(.NUM_MASTERS(NUM_MASTERS), .IDX_W(IDX_W)) u_picker (
    .req_i    (m_cyc_i),
    .last_i   (last_q),
    .winner_o (pick_win),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_GRANT;
          own_d   = pick_win;
          gnt_d   = NUM_MASTERS'(1) << pick_win;
        end
      end
      default: begin
        // Owner keeps the bus until it drops CYC; pending requests never pre-empt.
        if (!m_cyc_i[own_q]) begin
          state_d = ARB_IDLE;
          last_d  = own_q;
          gnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
    end
  end

  // Reset gates the slave side combinationally so nothing leaks out during a mid-cycle reset.
  assign active  = rst_i && (state_q == ARB_GRANT);
  assign gnt_o   = gnt_q;
  assign m_dat_o = s_dat_i;

  always_comb begin
    s_cyc_o = active & m_cyc_i[own_q] & ~abort;
    s_stb_o = active & m_stb_i[own_q] & ~abort;
    s_we_o  = active & m_we_i[own_q];
    s_adr_o = active ? m_adr_i[own_q] : '0;
    s_dat_o = active ? m_dat_i[own_q] : '0;
    m_ack_o = '0;
    if (active) m_ack_o[own_q] = s_ack_i;
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             err_hit;

  always_comb begin
    cnt_d   = cnt_q;
    abort_d = abort_q;
    err_hit = 1'b0;
    if (state_q != ARB_GRANT) begin
      cnt_d   = '0;
      abort_d = 1'b0;
    end else if (s_ack_i) begin
      cnt_d = '0;
    end else if (s_stb_o) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        err_hit = 1'b1;
        abort_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    m_err_o = '0;
    if (err_hit) m_err_o[own_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign abort = abort_q;
`else
  assign abort   = 1'b0;
  assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with a behavioural memory slave
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int N = 4;

  logic                        clk = 1'b0;
  logic                        rst_i;
  logic [N-1:0]                m_cyc_i, m_stb_i, m_we_i;
  logic [N-1:0][ADDR_WIDTH-1:0] m_adr_i;
  logic [N-1:0][DATA_WIDTH-1:0] m_dat_i;
  logic [DATA_WIDTH-1:0]       m_dat_o;
  logic [N-1:0]                m_ack_o, m_err_o, gnt_o;
  logic                        s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_WIDTH-1:0]       s_adr_o;
  logic [DATA_WIDTH-1:0]       s_dat_o, s_dat_i;
  logic                        s_ack_i;
  logic                        stall;

  always #1 clk = ~clk;

  wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  logic [31:0] mem [256];
  assign s_dat_i = mem[s_adr_o[7:0]];

  always @(posedge clk) begin
    if (!rst_i) begin
      s_ack_i <= 1'b0;
    end else if (s_cyc_o && s_stb_o && !s_ack_i && !stall) begin
      s_ack_i <= 1'b1;
      if (s_we_o) mem[s_adr_o[7:0]] <= s_dat_o;
    end else begin
      s_ack_i <= 1'b0;
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, output logic [31:0] rd);
    int n;
    m_stb_i[m] = 1'b1;
    m_we_i[m]  = we;
    m_adr_i[m] = adr;
    m_dat_i[m] = dat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_ack_o[m] !== 1'b1 && n < 10);
    check("ack_route", 32'(m_ack_o), 32'(1) << m);
    check("slave_adr", s_adr_o, adr);
    rd = m_dat_o;
    m_stb_i[m] = 1'b0;
    m_we_i[m]  = 1'b0;
  endtask

  task automatic do_reset();
    rst_i   = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  typedef struct {
    int         first;
    logic [3:0] req;
    logic [3:0] exp;
  } vec_t;

  vec_t        vecs[7];
  int          model_last;
  logic [31:0] mem_m [8];
  bit          mem_v [8];

  initial begin
    logic [31:0] rd;
    logic [3:0]  req;
    int          win, a, k;
    logic [31:0] d;

    vecs[0] = '{1, 4'b1111, 4'b0100};
    vecs[1] = '{1, 4'b0011, 4'b0001};
    vecs[2] = '{1, 4'b0010, 4'b0010};
    vecs[3] = '{3, 4'b1010, 4'b0010};
    vecs[4] = '{3, 4'b1000, 4'b1000};
    vecs[5] = '{0, 4'b1001, 4'b1000};
    vecs[6] = '{2, 4'b0101, 4'b0001};

    stall   = 1'b0;
    rst_i   = 1'b0;
    m_cyc_i = '1;
    m_stb_i = '0;
    m_we_i  = '0;
    m_adr_i = '0;
    m_dat_i = '0;

    repeat (3) begin
      @(negedge clk);
      check("rst_gnt", 32'(gnt_o), 32'd0);
      check("rst_scyc", 32'(s_cyc_o), 32'd0);
    end
    m_cyc_i = '0;
    rst_i   = 1'b1;
    @(negedge clk);

    m_cyc_i = 4'b0100;
    @(negedge clk);
    check("single_gnt", 32'(gnt_o), 32'b0100);
    xfer(2, 1'b1, 32'h10, 32'hA5, rd);
    xfer(2, 1'b0, 32'h10, 32'h0, rd);
    check("single_readback", rd, 32'hA5);
    m_cyc_i = '0;
    @(negedge clk);
    check("single_release", 32'(gnt_o), 32'd0);

    do_reset();
    m_cyc_i = '1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("rr_order", 32'(gnt_o), 32'(1) << (i % 4));
      xfer(i % 4, 1'b1, 32'h20 + 32'(i), 32'(i), rd);
      m_cyc_i[i % 4] = 1'b0;
      @(negedge clk);
      check("rr_idle_gap", 32'(gnt_o), 32'd0);
      if (i < 4) m_cyc_i[i % 4] = 1'b1;
      else m_cyc_i = '0;
      @(negedge clk);
    end

    m_cyc_i = 4'b1000;
    @(negedge clk);
    check("own_m3", 32'(gnt_o), 32'b1000);
    m_cyc_i[0] = 1'b1;
    xfer(3, 1'b1, 32'h30, 32'h33, rd);
    check("no_preempt", 32'(gnt_o), 32'b1000);
    @(negedge clk);
    check("no_preempt", 32'(gnt_o), 32'b1000);
    m_cyc_i[3] = 1'b0;
    @(negedge clk);
    check("handover_idle", 32'(gnt_o), 32'd0);
    @(negedge clk);
    check("handover_m0", 32'(gnt_o), 32'b0001);
    m_cyc_i = '0;
    @(negedge clk);
    @(negedge clk);

    m_cyc_i = 4'b0010;
    @(negedge clk);
    check("m1_gnt", 32'(gnt_o), 32'b0010);
    m_stb_i[1] = 1'b1;
    rst_i      = 1'b0;
    @(negedge clk);
    check("midrst_gnt", 32'(gnt_o), 32'd0);
    check("midrst_scyc", 32'(s_cyc_o), 32'd0);
    check("midrst_ack", 32'(m_ack_o), 32'd0);
    m_stb_i = '0;
    m_cyc_i = 4'b0011;
    rst_i   = 1'b1;
    @(negedge clk);
    check("post_rst_m0", 32'(gnt_o), 32'b0001);
    m_cyc_i = '0;
    @(negedge clk);

    foreach (vecs[i]) begin
      m_cyc_i = 4'(32'(1) << vecs[i].first);
      @(negedge clk);
      m_cyc_i = '0;
      @(negedge clk);
      m_cyc_i = vecs[i].req;
      @(negedge clk);
      check("table_gnt", 32'(gnt_o), 32'(vecs[i].exp));
      m_cyc_i = '0;
      @(negedge clk);
    end

    do_reset();
    model_last = N - 1;
    for (int it = 0; it < 24; it++) begin
      req = 4'($urandom_range(1, 15));
      win = -1;
      for (int o = 1; o <= N; o++) begin
        if (win < 0 && req[(model_last + o) % N]) win = (model_last + o) % N;
      end
      m_cyc_i = req;
      @(negedge clk);
      check("rand_gnt", 32'(gnt_o), 32'(1) << win);
      a = $urandom_range(0, 7);
      if (mem_v[a] && $urandom_range(0, 1) == 1) begin
        xfer(win, 1'b0, 32'h40 + 32'(a), 32'h0, rd);
        check("rand_read", rd, mem_m[a]);
      end else begin
        d = $urandom;
        xfer(win, 1'b1, 32'h40 + 32'(a), d, rd);
        mem_m[a] = d;
        mem_v[a] = 1'b1;
      end
      m_cyc_i = '0;
      @(negedge clk);
      check("rand_idle", 32'(gnt_o), 32'd0);
      model_last = win;
    end

`ifdef WB_ARB_TIMEOUT_EN
    stall   = 1'b1;
    m_cyc_i = 4'b0100;
    @(negedge clk);
    m_stb_i[2] = 1'b1;
    m_adr_i[2] = 32'h50;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_err_o[2] !== 1'b1 && k < 40);
    check("err_cycle", 32'(k + 1), 32'd16);
    check("err_onehot", 32'(m_err_o), 32'b0100);
    @(negedge clk);
    check("err_pulse", 32'(m_err_o), 32'd0);
    check("abort_scyc", 32'(s_cyc_o), 32'd0);
    check("abort_hold_gnt", 32'(gnt_o), 32'b0100);
    m_stb_i = '0;
    m_cyc_i = '0;
    @(negedge clk);
    check("abort_release", 32'(gnt_o), 32'd0);
    stall = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
